// File: rtl/conv_tile_sequencer.sv
// Layer scheduler: walks the output map in tiles of up to SA_HEIGHT pixels,
// driving router clear/enable/unstall and systolic-array launch per tile.
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | waiting for i_start
// S_CLEAR   | one-cycle router counter clear
// S_LOAD    | router enabled, one row per unheld cycle
// S_START   | one-cycle systolic array launch
// S_COMPUTE | waiting for i_sa_done
// S_ADVANCE | tile bookkeeping, router unstall pulse
// S_DONE    | one-cycle layer-complete pulse
// S_ABORT   | router cleared, layer abandoned
module conv_tile_sequencer #(
  parameter int SA_HEIGHT  = 4,
  parameter int ADDR_WIDTH = 6,
  localparam int RW = $clog2(SA_HEIGHT + 1),
  localparam int TW = 2 * ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_o_size,
  input  logic                  i_hold,
  input  logic                  i_sa_done,
  output logic                  o_router_clear,
  output logic                  o_router_en,
  output logic                  o_compute_done,
  output logic                  o_sa_start,
  output logic [RW-1:0]         o_rows_loaded,
  output logic [TW-1:0]         o_tiles_done,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_START, S_COMPUTE, S_ADVANCE, S_DONE, S_ABORT
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] remaining_q;
  logic [RW-1:0] rows_q;
  logic [TW-1:0] tiles_q;
  logic          abort_now;
  logic          last_row;
  logic          last_pix;

  // ABORT itself always falls back to IDLE so a held abort cannot loop
  assign abort_now = i_abort && (state_q != S_IDLE) && (state_q != S_ABORT);
  assign last_row  = (rows_q == RW'(SA_HEIGHT - 1));
  assign last_pix  = (remaining_q == TW'(1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_now) begin
      state_d = S_ABORT;
    end else begin
      unique case (state_q)
        S_IDLE:    if (i_start) state_d = (i_o_size == '0) ? S_DONE : S_CLEAR;
        S_CLEAR:   state_d = S_LOAD;
        S_LOAD:    if (!i_hold && (last_row || last_pix)) state_d = S_START;
        S_START:   state_d = S_COMPUTE;
        S_COMPUTE: if (i_sa_done) state_d = S_ADVANCE;
        S_ADVANCE: state_d = (remaining_q == '0) ? S_DONE : S_LOAD;
        S_DONE:    state_d = S_IDLE;
        S_ABORT:   state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_router_clear = (state_q == S_CLEAR) || (state_q == S_ABORT);
    o_router_en    = (state_q == S_LOAD) && !i_hold;
    o_sa_start     = (state_q == S_START);
    o_compute_done = (state_q == S_ADVANCE);
    o_done         = (state_q == S_DONE);
    o_busy         = (state_q != S_IDLE);
  end

  // Counters freeze on the abort cycle so the abandoned layer stays visible
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      remaining_q <= '0;
      rows_q      <= '0;
      tiles_q     <= '0;
    end else if (!abort_now) begin
      case (state_q)
        S_IDLE: if (i_start) begin
          remaining_q <= TW'(i_o_size) * TW'(i_o_size);
          rows_q      <= '0;
          tiles_q     <= '0;
        end
        S_LOAD: if (!i_hold) begin
          rows_q      <= rows_q + RW'(1);
          remaining_q <= remaining_q - TW'(1);
        end
        S_ADVANCE: begin
          tiles_q <= tiles_q + TW'(1);
          rows_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_rows_loaded = rows_q;
  assign o_tiles_done  = tiles_q;

endmodule
